fp_norm_round: RTL and testbench

Post-normalisation and rounding stage for the FP datapath. It sits directly downstream of the multiplier/adder mantissa stages and consumes their unnormalised result: a sign, a wide pre-norm mantissa and an extended signed exponent. It normalises, rounds per the selected rounding mode, packs an IEEE word, and raises exception flags. The stage is a 2-deep pipeline with valid/ready back-pressure.

---
 rtl/fp_norm_round_pkg.sv | 30 +++
 rtl/fp_lzc.sv | 21 ++
 rtl/fp_norm_round.sv | 196 +++++++++++++++++++
 tb/tb_fp_norm_round.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_norm_round_pkg.sv
// rtl/fp_norm_round_pkg.sv - shared FP datapath definitions (widths, rounding modes, flag bundle)
package fp_defs;

  localparam int C_OP           = 32;
  localparam int C_MANT         = 23;
  localparam int C_EXP          = 8;
  localparam int C_MANT_PRENORM = 48;
  localparam int C_EXP_PRENORM  = 10;
  localparam int C_BIAS         = 2 ** (C_EXP - 1) - 1;

  typedef enum logic [2:0] {
    C_RM_NEAREST  = 3'd0,
    C_RM_TRUNC    = 3'd1,
    C_RM_MINUSINF = 3'd2,
    C_RM_PLUSINF  = 3'd3
  } fp_rm_e;

  typedef struct packed {
    logic                      sign;
    logic [C_EXP_PRENORM-1:0]  exp;
    logic [C_MANT_PRENORM-1:0] mant;
  } fp_prenorm_t;

  typedef struct packed {
    logic of;
    logic uf;
    logic nx;
  } fp_flags_t;

endpackage

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - leading-zero counter; cnt_o = W when the input is all zero
module fp_lzc #(
  parameter  int W  = 47,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  data_i,
  output logic [CW-1:0] cnt_o,
  output logic          zero_o
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    cnt_o = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (data_i[i]) cnt_o = CW'(W - 1 - i);
    end
  end

  assign zero_o = ~|data_i;

endmodule

// File: rtl/fp_norm_round.sv
// rtl/fp_norm_round.sv - 2-stage normalise/round/pack stage with valid/ready back-pressure
// Gradual underflow is built when FP_NORM_ROUND_DENORMAL_EN is defined, otherwise tiny results flush to zero.
module fp_norm_round
  import fp_defs::*;
#(
  parameter int OP_W       = C_OP,
  parameter int MANT_W     = C_MANT,
  parameter int EXP_W      = C_EXP,
  parameter int MANT_PRE_W = C_MANT_PRENORM,
  parameter int EXP_PRE_W  = C_EXP_PRENORM
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  sign_i,
  input  logic [EXP_PRE_W-1:0]  exp_i,
  input  logic [MANT_PRE_W-1:0] mant_i,
  input  logic [2:0]            rm_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [OP_W-1:0]       result_o,
  output logic                  of_o,
  output logic                  uf_o,
  output logic                  nx_o
);

  localparam int NORM_W = MANT_PRE_W - 1;
  localparam int IE_W   = EXP_PRE_W + 1;
  localparam int LZ_W   = $clog2(NORM_W + 1);
  localparam int G_IDX  = NORM_W - 2 - MANT_W;

  localparam logic [IE_W-1:0] EXP_ALL1 = IE_W'(2 ** EXP_W - 1);
  localparam logic [OP_W-2:0] INF_MAG  = {{EXP_W{1'b1}}, {MANT_W{1'b0}}};
  localparam logic [OP_W-2:0] MAX_MAG  = {{(EXP_W-1){1'b1}}, 1'b0, {MANT_W{1'b1}}};

  logic s1_valid, s2_valid, s1_en, s2_en;

  assign s2_en   = !s2_valid || ready_i;
  assign s1_en   = !s1_valid || s2_en;
  assign ready_o = s1_en;

  // ---------------- stage 1: normalise ----------------
  logic [NORM_W-1:0] lz_in, norm_d;
  logic [LZ_W-1:0]   lz_cnt;
  logic              lz_zero, sticky_d;
  logic [IE_W-1:0]   exp_ext, exp_d;

  assign lz_in   = mant_i[MANT_PRE_W-2:0];
  assign exp_ext = {exp_i[EXP_PRE_W-1], exp_i};

  fp_lzc #(.W(NORM_W)) u_lzc (
    .data_i (lz_in),
    .cnt_o  (lz_cnt),
    .zero_o (lz_zero)
  );

  always_comb begin
    norm_d   = lz_in << lz_cnt;
    sticky_d = 1'b0;
    exp_d    = exp_ext - {{(IE_W-LZ_W){1'b0}}, lz_cnt};
    if (mant_i[MANT_PRE_W-1]) begin
      norm_d   = mant_i[MANT_PRE_W-1:1];
      sticky_d = mant_i[0];
      exp_d    = exp_ext + IE_W'(1);
    end
  end

  logic              s1_sign, s1_sticky, s1_zero;
  logic [IE_W-1:0]   s1_exp;
  logic [NORM_W-1:0] s1_norm;
  logic [2:0]        s1_rm;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_exp    <= '0;
      s1_norm   <= '0;
      s1_sticky <= 1'b0;
      s1_rm     <= '0;
      s1_zero   <= 1'b0;
    end else if (s1_en) begin
      s1_valid <= valid_i;
      if (valid_i) begin
        s1_sign   <= sign_i;
        s1_exp    <= exp_d;
        s1_norm   <= norm_d;
        s1_sticky <= sticky_d;
        s1_rm     <= rm_i;
        s1_zero   <= !mant_i[MANT_PRE_W-1] && lz_zero;
      end
    end
  end

  // ---------------- stage 2: round and pack ----------------
  logic              tiny, g_bit, s_bit, inexact, up, ovf, r_sticky;
  logic [NORM_W-1:0] r_mant;
  logic [IE_W-1:0]   e_base, final_exp;
  logic [MANT_W:0]   sig;
  logic [MANT_W+1:0] sum;
  logic [OP_W-1:0]   res_d;
  fp_flags_t         flags_d;

  assign tiny = s1_exp[IE_W-1] || (s1_exp == '0);

`ifdef FP_NORM_ROUND_DENORMAL_EN
  logic [IE_W-1:0]     den_diff;
  logic [LZ_W-1:0]     den_sh;
  logic [2*NORM_W-1:0] den_wide;

  assign den_diff = IE_W'(1) - s1_exp;
  assign den_sh   = (den_diff >= IE_W'(NORM_W)) ? LZ_W'(NORM_W) : den_diff[LZ_W-1:0];
  assign den_wide = {s1_norm, {NORM_W{1'b0}}} >> (tiny ? den_sh : LZ_W'(0));

  always_comb begin
    r_mant   = den_wide[2*NORM_W-1:NORM_W];
    r_sticky = s1_sticky || (|den_wide[NORM_W-1:0]);
    e_base   = tiny ? '0 : s1_exp - IE_W'(1);
  end
`else
  always_comb begin
    r_mant   = s1_norm;
    r_sticky = s1_sticky;
    e_base   = s1_exp - IE_W'(1);
  end
`endif

  // The top two sum bits carry the hidden bit plus any rounding carry, so adding
  // them to (exp - 1) gives the final exponent for normal and subnormal results alike.
  always_comb begin
    sig     = r_mant[NORM_W-1 -: MANT_W+1];
    g_bit   = r_mant[G_IDX];
    s_bit   = (|r_mant[G_IDX-1:0]) || r_sticky;
    inexact = g_bit || s_bit;
    case (s1_rm)
      C_RM_NEAREST:  up = g_bit && (s_bit || sig[0]);
      C_RM_PLUSINF:  up = inexact && !s1_sign;
      C_RM_MINUSINF: up = inexact && s1_sign;
      default:       up = 1'b0;
    endcase
    sum       = {1'b0, sig} + {{(MANT_W+1){1'b0}}, up};
    final_exp = e_base + {{(IE_W-2){1'b0}}, sum[MANT_W+1:MANT_W]};
    ovf       = !tiny && (final_exp >= EXP_ALL1);

    res_d      = {s1_sign, final_exp[EXP_W-1:0], sum[MANT_W-1:0]};
    flags_d.of = 1'b0;
    flags_d.uf = 1'b0;
    flags_d.nx = inexact;
    if (s1_zero) begin
      res_d      = {s1_sign, {(OP_W-1){1'b0}}};
      flags_d.nx = 1'b0;
    end else if (tiny) begin
`ifdef FP_NORM_ROUND_DENORMAL_EN
      flags_d.uf = inexact;
`else
      res_d      = {s1_sign, {(OP_W-1){1'b0}}};
      flags_d.uf = 1'b1;
      flags_d.nx = 1'b1;
`endif
    end else if (ovf) begin
      flags_d.of = 1'b1;
      flags_d.nx = 1'b1;
      case (s1_rm)
        C_RM_NEAREST:  res_d = {s1_sign, INF_MAG};
        C_RM_PLUSINF:  res_d = {s1_sign, s1_sign ? MAX_MAG : INF_MAG};
        C_RM_MINUSINF: res_d = {s1_sign, s1_sign ? INF_MAG : MAX_MAG};
        default:       res_d = {s1_sign, MAX_MAG};
      endcase
    end
  end

  logic [OP_W-1:0] s2_result;
  fp_flags_t       s2_flags;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_flags  <= '0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_result <= res_d;
        s2_flags  <= flags_d;
      end
    end
  end

  assign valid_o  = s2_valid;
  assign result_o = s2_result;
  assign of_o     = s2_flags.of;
  assign uf_o     = s2_flags.uf;
  assign nx_o     = s2_flags.nx;

endmodule

// File: tb/tb_fp_norm_round.sv
// tb/tb_fp_norm_round.sv - self-checking bench: directed table, back-pressure/reset sequences, random vs reference model
module tb_fp_norm_round;

  logic        clk_i = 1'b0;
  logic        rst_ni, valid_i, ready_o, sign_i, valid_o, ready_i, of_o, uf_o, nx_o;
  logic [9:0]  exp_i;
  logic [47:0] mant_i;
  logic [2:0]  rm_i;
  logic [31:0] result_o;

  always #5 clk_i = ~clk_i;

  fp_norm_round dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .sign_i   (sign_i),
    .exp_i    (exp_i),
    .mant_i   (mant_i),
    .rm_i     (rm_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .of_o     (of_o),
    .uf_o     (uf_o),
    .nx_o     (nx_o)
  );

  typedef struct packed { logic [31:0] res; logic [2:0] flg; } exp_t;  // flg = {of, uf, nx}
  typedef struct { logic s; logic [9:0] ex; logic [47:0] m; logic [2:0] rm; exp_t e; } vec_t;

  int   n_chk = 0, n_fail = 0;
  exp_t q_exp[$];
  exp_t mon_e;
  bit   rnd_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Value = m * 2^(ex - 173); round to an ulp of 2^(max(e,1) - 150) with integer arithmetic.
  function automatic exp_t ref_model(input logic s, input logic [9:0] ex, input logic [47:0] m,
                                     input logic [2:0] rm);
    exp_t r;
    int p, e, eb, k, ef;
    longint unsigned mm, q, rem, half;
    logic gt, eq, inx, up;
    mm = 64'(m);
    eb = int'($signed(ex));
    r.res = {s, 31'd0};
    r.flg = 3'b000;
    if (m == 48'd0) return r;
    p = 0;
    for (int i = 0; i < 48; i++) if (m[i]) p = i;
    e = eb + p - 46;
`ifndef FP_NORM_ROUND_DENORMAL_EN
    if (e <= 0) begin
      r.flg = 3'b011;
      return r;
    end
`endif
    k = ((e < 1) ? 1 : e) - eb + 23;
    gt = 0; eq = 0; inx = 0; q = 0;
    if (k <= 0) q = mm << (-k);
    else if (k >= 64) inx = 1;
    else begin
      q    = mm >> k;
      rem  = mm & ((64'd1 << k) - 64'd1);
      half = 64'd1 << (k - 1);
      gt   = rem > half;
      eq   = rem == half;
      inx  = rem != 0;
    end
    case (rm)
      3'd0:    up = gt | (eq & q[0]);
      3'd2:    up = inx & s;
      3'd3:    up = inx & !s;
      default: up = 1'b0;
    endcase
    q = q + 64'(up);
    if (e >= 1) begin
      if (q >= (64'd1 << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
      ef = e;
    end else begin
      ef = (q >= (64'd1 << 23)) ? 1 : 0;
    end
    if (ef >= 255) begin
      r.flg = 3'b101;
      case (rm)
        3'd0:    r.res = {s, 31'h7F800000};
        3'd2:    r.res = {s, s ? 31'h7F800000 : 31'h7F7FFFFF};
        3'd3:    r.res = {s, s ? 31'h7F7FFFFF : 31'h7F800000};
        default: r.res = {s, 31'h7F7FFFFF};
      endcase
    end else begin
      r.res = {s, ef[7:0], q[22:0]};
      r.flg = {1'b0, (e <= 0) & inx, inx};
    end
    return r;
  endfunction

  function automatic vec_t mkv(input logic s, input logic [9:0] ex, input logic [47:0] m,
                               input logic [2:0] rm, input logic [31:0] res, input logic [2:0] flg);
    vec_t v;
    v.s = s; v.ex = ex; v.m = m; v.rm = rm; v.e.res = res; v.e.flg = flg;
    return v;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input vec_t v);
    int guard;
    sign_i = v.s; exp_i = v.ex; mant_i = v.m; rm_i = v.rm; valid_i = 1'b1;
    guard = 0;
    @(negedge clk_i);
    while (!ready_o && guard < 200) begin
      @(negedge clk_i);
      guard++;
    end
    if (!ready_o) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout actual=ready_o_low required=accept");
    end else begin
      q_exp.push_back(v.e);
    end
    @(posedge clk_i); #1;
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (q_exp.size() != 0 && g < 500) begin
      @(negedge clk_i);
      g++;
    end
    check("drain_pending", 32'(q_exp.size()), 32'd0);
    @(posedge clk_i); #1;
  endtask

  always @(negedge clk_i) begin
    if (rst_ni && valid_o && ready_i) begin
      if (q_exp.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_output actual=%h required=no_output", result_o);
      end else begin
        mon_e = q_exp.pop_front();
        check("result", result_o, mon_e.res);
        check("flags", 32'({of_o, uf_o, nx_o}), 32'(mon_e.flg));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  localparam logic [47:0] ONE  = 48'h4000_0000_0000;
  localparam logic [47:0] ALL1 = 48'h7FFF_FFC0_0000;

  vec_t tbl[18];
  vec_t v;
  logic [31:0] held;
  longint unsigned w;

  initial begin
    tbl[0]  = mkv(0, 10'd127, ONE,                     3'd0, 32'h3F800000, 3'b000);
    tbl[1]  = mkv(0, 10'd127, 48'h8000_0000_0000,      3'd0, 32'h40000000, 3'b000);
    tbl[2]  = mkv(1, 10'd55,  48'd0,                   3'd0, 32'h80000000, 3'b000);
    tbl[3]  = mkv(0, 10'd127, ONE | 48'h40_0000,       3'd0, 32'h3F800000, 3'b001);
    tbl[4]  = mkv(0, 10'd127, ONE | 48'hC0_0000,       3'd0, 32'h3F800002, 3'b001);
    tbl[5]  = mkv(0, 10'd127, ONE | 48'h1_0000,        3'd3, 32'h3F800001, 3'b001);
    tbl[6]  = mkv(1, 10'd127, ONE | 48'h1_0000,        3'd2, 32'hBF800001, 3'b001);
    tbl[7]  = mkv(0, 10'd255, ONE,                     3'd0, 32'h7F800000, 3'b101);
    tbl[8]  = mkv(0, 10'd255, ONE,                     3'd1, 32'h7F7FFFFF, 3'b101);
    tbl[9]  = mkv(1, 10'd255, ONE,                     3'd3, 32'hFF7FFFFF, 3'b101);
`ifdef FP_NORM_ROUND_DENORMAL_EN
    tbl[10] = mkv(0, 10'd0,   ONE,                     3'd0, 32'h00400000, 3'b000);
`else
    tbl[10] = mkv(0, 10'd0,   ONE,                     3'd0, 32'h00000000, 3'b011);
`endif
    tbl[11] = mkv(0, 10'h338, ONE,                     3'd0, 32'h00000000, 3'b011);
    tbl[12] = mkv(0, 10'd127, ALL1,                    3'd0, 32'h40000000, 3'b001);
    tbl[13] = mkv(0, 10'd127, ONE | 48'hC0_0000,       3'd5, 32'h3F800001, 3'b001);
    tbl[14] = mkv(0, 10'd254, ALL1,                    3'd0, 32'h7F800000, 3'b101);
    tbl[15] = mkv(0, 10'd173, 48'd1,                   3'd0, 32'h3F800000, 3'b000);
    tbl[16] = mkv(1, 10'd255, ONE,                     3'd2, 32'hFF800000, 3'b101);
    tbl[17] = mkv(0, 10'd1,   ONE,                     3'd1, 32'h00800000, 3'b000);

    rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    sign_i = 1'b0; exp_i = '0; mant_i = '0; rm_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_valid_o", 32'(valid_o), 32'd0);
    check("reset_result_o", result_o, 32'd0);
    check("reset_flags", 32'({of_o, uf_o, nx_o}), 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("post_reset_ready_o", 32'(ready_o), 32'd1);
    @(posedge clk_i); #1;

    // Two-cycle latency on an idle pipe.
    send(tbl[0]);
    @(negedge clk_i);
    check("latency_cycle1_valid_o", 32'(valid_o), 32'd0);
    @(negedge clk_i);
    check("latency_cycle2_valid_o", 32'(valid_o), 32'd1);
    @(posedge clk_i); #1;
    drain();

    for (int i = 0; i < 18; i++) send(tbl[i]);
    drain();

    // Back-pressure: two accepted then ready_o drops, output holds.
    ready_i = 1'b0;
    sign_i = tbl[4].s; exp_i = tbl[4].ex; mant_i = tbl[4].m; rm_i = tbl[4].rm; valid_i = 1'b1;
    @(negedge clk_i);
    check("bp_ready_first", 32'(ready_o), 32'd1);
    q_exp.push_back(tbl[4].e);
    @(posedge clk_i); #1;
    sign_i = tbl[5].s; exp_i = tbl[5].ex; mant_i = tbl[5].m; rm_i = tbl[5].rm;
    @(negedge clk_i);
    check("bp_ready_second", 32'(ready_o), 32'd1);
    q_exp.push_back(tbl[5].e);
    @(posedge clk_i); #1;
    sign_i = tbl[6].s; exp_i = tbl[6].ex; mant_i = tbl[6].m; rm_i = tbl[6].rm;
    @(negedge clk_i);
    check("bp_ready_full", 32'(ready_o), 32'd0);
    check("bp_valid_o", 32'(valid_o), 32'd1);
    check("bp_head_result", result_o, tbl[4].e.res);
    held = result_o;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("bp_result_stable", result_o, held);
      check("bp_ready_held_low", 32'(ready_o), 32'd0);
    end
    @(posedge clk_i); #1;
    ready_i = 1'b1;
    send(tbl[6]);
    send(tbl[7]);
    drain();

    // Random stimulus with random downstream stalls.
    rnd_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 400; n++) begin
          w = {$urandom(), $urandom()};
          v.m = w[47:0] >> $urandom_range(0, 47);
          if ($urandom_range(0, 15) == 0) v.m = '0;
          case ($urandom_range(0, 3))
            0:       v.ex = 10'($urandom_range(0, 1023));
            1:       v.ex = 10'($urandom_range(100, 160));
            2:       v.ex = 10'($urandom_range(200, 300));
            default: v.ex = 10'(int'($urandom_range(0, 90)) - 30);
          endcase
          v.s  = 1'($urandom_range(0, 1));
          v.rm = 3'($urandom_range(0, 7));
          v.e  = ref_model(v.s, v.ex, v.m, v.rm);
          send(v);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk_i); #1;
          ready_i = ($urandom_range(0, 3) != 0);
        end
        ready_i = 1'b1;
      end
    join
    drain();

    // Reset mid-stream: in-flight results are discarded.
    send(tbl[1]);
    send(tbl[3]);
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    q_exp.delete();
    @(negedge clk_i);
    check("midreset_valid_o", 32'(valid_o), 32'd0);
    check("midreset_result_o", result_o, 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("midreset_no_stale_valid", 32'(valid_o), 32'd0);
    end
    @(posedge clk_i); #1;
    send(tbl[12]);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
